// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing the single port of the 32 x 32-bit register bank
// between four requesters through a fixed grant / access / acknowledge sequence.
module reg_bank_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_REQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]        rb_rdata,
  output logic [ADDR_W-1:0]        rb_addr,
  output logic                     rb_we,
  output logic [DATA_W-1:0]        rb_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    ack_q;
  logic                rb_we_q;
  logic [ADDR_W-1:0]   rb_addr_q;
  logic [DATA_W-1:0]   rb_wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;

  logic                found_d;
  logic [IDX_W-1:0]    win_d;
  logic [N_REQ-1:0]    gnt_d;
  logic                win_we_d;
  logic [ADDR_W-1:0]   win_addr_d;
  logic [DATA_W-1:0]   win_wdata_d;

  // Search starts just after the last winner, so the previous owner ranks last.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    found_d = 1'b0;
    win_d   = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last_q) + i) % N_REQ;
      if (!found_d && req[idx]) begin
        found_d = 1'b1;
        win_d   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    win_we_d    = 1'b0;
    win_addr_d  = '0;
    win_wdata_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == win_d) begin
        gnt_d[i]    = 1'b1;
        win_we_d    = we[i];
        win_addr_d  = addr[i*ADDR_W +: ADDR_W];
        win_wdata_d = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(N_REQ - 1);
      gnt_q      <= '0;
      ack_q      <= '0;
      rb_we_q    <= 1'b0;
      rb_addr_q  <= '0;
      rb_wdata_q <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      gnt_q   <= '0;
      ack_q   <= '0;
      rb_we_q <= 1'b0;
      case (state_q)
        ACCESS: begin
          state_q <= DONE;
          ack_q   <= gnt_q;
          busy_q  <= 1'b1;
          if (!rb_we_q) begin
            rdata_q <= rb_rdata;
          end
        end
        // IDLE and DONE are both decision points; DONE may chain into a new ACCESS.
        IDLE, DONE: begin
          if (found_d) begin
            state_q    <= ACCESS;
            last_q     <= win_d;
            gnt_q      <= gnt_d;
            rb_we_q    <= win_we_d;
            rb_addr_q  <= win_addr_d;
            rb_wdata_q <= win_wdata_d;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign rb_we    = rb_we_q;
  assign rb_addr  = rb_addr_q;
  assign rb_wdata = rb_wdata_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter with a behavioural 32 x 32 register bank.
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [19:0] addr = '0;
  logic [127:0] wdata = '0;
  logic [31:0] rb_rdata;
  logic [4:0]  rb_addr;
  logic        rb_we;
  logic [31:0] rb_wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [31:0] rdata;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [3:0]  ackv;
    logic        is_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] bank [32];
  logic        bank_ok = 1'b0;

  reg_bank_arbiter #(
    .DATA_W (32),
    .ADDR_W (5),
    .N_REQ  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rb_rdata (rb_rdata),
    .rb_addr  (rb_addr),
    .rb_we    (rb_we),
    .rb_wdata (rb_wdata),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign rb_rdata = bank[rb_addr];

  always @(posedge clk) begin
    if (!bank_ok) begin
      for (int i = 0; i < 32; i++) begin
        bank[i] <= 32'hA000_0000 | 32'(i);
      end
      bank[5] <= 32'hDEAD_BEEF;
      bank_ok <= 1'b1;
    end else if (rb_we) begin
      bank[rb_addr] <= rb_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexp_ack", {28'b0, ack}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("ack", {28'b0, ack}, {28'b0, mon_e.ackv});
        if (mon_e.is_rd) begin
          check("rdata", rdata, mon_e.rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [4:0] a, input logic [31:0] d);
    we[p]            = w;
    addr[p*5 +: 5]   = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic push(input logic [3:0] a, input logic r, input logic [31:0] d);
    exp_t e;
    e.ackv  = a;
    e.is_rd = r;
    e.rd    = d;
    sb.push_back(e);
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};

    #1;
    check("rst_gnt", {28'b0, gnt}, 32'h0);
    check("rst_ack", {28'b0, ack}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_we", {31'b0, rb_we}, 32'h0);
    check("rst_addr", {27'b0, rb_addr}, 32'h0);
    check("rst_wdata", rb_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Read of reg 5 by requester 2
    set_port(2, 1'b0, 5'd5, 32'h0);
    req = 4'b0100;
    push(4'b0100, 1'b1, 32'hDEAD_BEEF);
    tick();
    check("t1_gnt", {28'b0, gnt}, 32'h4);
    check("t1_addr", {27'b0, rb_addr}, 32'd5);
    check("t1_we", {31'b0, rb_we}, 32'h0);
    check("t1_busy", {31'b0, busy}, 32'h1);
    req = 4'b0000;
    tick();
    check("t1_gnt_done", {28'b0, gnt}, 32'h0);
    check("t1_busy_done", {31'b0, busy}, 32'h1);
    tick();
    check("t1_busy_fall", {31'b0, busy}, 32'h0);

    // Write by requester 1, read back by requester 0
    set_port(1, 1'b1, 5'd31, 32'h1234_5678);
    req = 4'b0010;
    push(4'b0010, 1'b0, 32'h0);
    tick();
    check("t2_we", {31'b0, rb_we}, 32'h1);
    check("t2_addr", {27'b0, rb_addr}, 32'd31);
    check("t2_wdata", rb_wdata, 32'h1234_5678);
    check("t2_gnt", {28'b0, gnt}, 32'h2);
    req = 4'b0000;
    tick();
    check("t2_we_drop", {31'b0, rb_we}, 32'h0);
    tick();
    set_port(0, 1'b0, 5'd31, 32'h0);
    req = 4'b0001;
    push(4'b0001, 1'b1, 32'h1234_5678);
    tick();
    check("t2_rd_gnt", {28'b0, gnt}, 32'h1);
    req = 4'b0000;
    repeat (2) tick();

    // Continuous demand from all four after reset release
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) set_port(p, 1'b0, 5'(10 + p), 32'h0);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) push(4'b0001 << order[k], 1'b1, 32'hA000_000A + 32'(order[k]));
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i % 2 == 0) check("t3_gnt", {28'b0, gnt}, {28'b0, 4'b0001 << order[i/2]});
      else check("t3_gap", {28'b0, gnt}, 32'h0);
      check("t3_busy", {31'b0, busy}, 32'h1);
      if (i == 10) req = 4'b0000;
    end
    tick();
    check("t3_idle", {31'b0, busy}, 32'h0);

    // Requester 3 granted, then 0 and 3 contend
    set_port(3, 1'b0, 5'd13, 32'h0);
    set_port(0, 1'b0, 5'd10, 32'h0);
    req = 4'b1000;
    push(4'b1000, 1'b1, 32'hA000_000D);
    push(4'b0001, 1'b1, 32'hA000_000A);
    push(4'b1000, 1'b1, 32'hA000_000D);
    tick();
    check("t4_gnt3", {28'b0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    check("t4_gnt0", {28'b0, gnt}, 32'h1);
    req = 4'b1000;
    tick();
    tick();
    check("t4_gnt3b", {28'b0, gnt}, 32'h8);
    req = 4'b0000;
    repeat (2) tick();

    // Reset during the ACCESS of a write by requester 1
    set_port(1, 1'b1, 5'd7, 32'hCAFE_F00D);
    req = 4'b0010;
    tick();
    check("t5_we_pre", {31'b0, rb_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_we_rst", {31'b0, rb_we}, 32'h0);
    check("t5_gnt_rst", {28'b0, gnt}, 32'h0);
    check("t5_busy_rst", {31'b0, busy}, 32'h0);
    #1;
    rst_n = 1'b1;
    set_port(1, 1'b0, 5'd7, 32'h0);
    set_port(2, 1'b0, 5'd8, 32'h0);
    req = 4'b0110;
    push(4'b0010, 1'b1, 32'hA000_0007);
    push(4'b0100, 1'b1, 32'hA000_0008);
    tick();
    check("t5_gnt1", {28'b0, gnt}, 32'h2);
    req = 4'b0100;
    tick();
    tick();
    check("t5_gnt2", {28'b0, gnt}, 32'h4);
    req = 4'b0000;
    repeat (2) tick();

    // Short req[0] pulse inside another port's ACCESS
    set_port(1, 1'b1, 5'd20, 32'h55AA_55AA);
    set_port(0, 1'b0, 5'd3, 32'h0);
    req = 4'b0010;
    push(4'b0010, 1'b0, 32'h0);
    tick();
    check("t6_gnt1", {28'b0, gnt}, 32'h2);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    check("t6_busy", {31'b0, busy}, 32'h0);
    check("t6_gnt", {28'b0, gnt}, 32'h0);
    repeat (2) tick();
    check("t6_gnt_late", {28'b0, gnt}, 32'h0);
    check("t6_rdata", rdata, 32'hA000_0008);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin access arbiter that shares the single port of the 32 x 32-bit register bank between four requesters (`N_REQ` = 4). The read side of the bank is a purely combinational 32:1 mux tree selected by `rb_addr`, so the arbiter sequences each transaction through a fixed grant/access/acknowledge cycle. It returns registered read data and acknowledges each requester individually. The block sits between the bank and its clients, such as the datapath read/write stages and the debug/load port.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width (32 registers)
- `N_REQ`, 4, number of requesters; the implementation only needs to support 4

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request level
- `we`  in  N_REQ  per-requester write enable (1 = write, 0 = read)
- `addr`  in  N_REQ*ADDR_W  packed register indices; requester i uses bits [i*5 +: 5]
- `wdata`  in  N_REQ*DATA_W  packed write data; requester i uses bits [i*32 +: 32]
- `rb_rdata`  in  DATA_W  combinational read data from the bank mux tree
- `rb_addr`  out  ADDR_W  bank select, drives the read-mux select and the write decoder
- `rb_we`  out  1  bank write strobe
- `rb_wdata`  out  DATA_W  bank write data
- `gnt`  out  N_REQ  one-hot; marks the requester owning the bank this cycle
- `ack`  out  N_REQ  one-hot single-cycle completion pulse
- `rdata`  out  DATA_W  registered read result
- `busy`  out  1  high whenever state is not IDLE

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE:**
  - If any `req` bit is high at the clock edge, pick the winner round-robin, latch its `we`/`addr`/`wdata`, and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS (exactly 1 cycle):**
  - `gnt[w]` = 1, `rb_addr` = latched address.
  - Write: `rb_we` = 1 and `rb_wdata` = latched data.
  - Read: `rb_we` = 0, and `rdata` is loaded from `rb_rdata` at the end of the cycle.
  - Next state is DONE.
- **DONE (exactly 1 cycle):**
  - `ack[w]` = 1.
  - If any `req` bit is high at the edge (including `req[w]`, now counted as a new request), arbitrate and go straight to ACCESS; otherwise go to IDLE.
- **Arbitration:**
  - A pointer `last` holds the most recently granted index.
  - Search order is `last+1, last+2, …` modulo N_REQ; the first asserted `req` wins.
  - `last` updates to the winner on entry to ACCESS.
- Requests are sampled only at decision edges (IDLE, or DONE→next). A request raised and dropped between decision edges is never granted. A request dropped after being latched still completes, using the latched values.
- A requester must treat the `ack` cycle as completion and deassert `req` in that same cycle unless it wants another transaction.
- `rdata` keeps its value until the next read completes; writes do not change it.
- Outside ACCESS: `rb_we` = 0 and `gnt` = 0. `rb_addr`/`rb_wdata` hold their last latched values.
- The address is passed through unmodified; all 32 indices are valid and there is no wrap or range check.

## Timing
- Reset (async, `rst_n` = 0), effective immediately, no clock needed:
  - state = IDLE, `last` = N_REQ-1 (port 0 has first priority).
  - `gnt`, `ack`, `rb_we`, `busy` = 0.
  - `rb_addr`, `rb_wdata`, `rdata` = 0.
- Reset asserted mid-ACCESS drops `rb_we` combinationally-from-state, so no partial write follows. The pending transaction is discarded with no `ack`.
- Latency: `req` high at edge k from IDLE → ACCESS in cycle k+1 → `ack` and valid `rdata` in cycle k+2.
- Throughput: one transaction per 2 cycles under continuous demand. `busy` stays high throughout.
- Simultaneous requests are resolved only by the round-robin pointer; no requester waits more than N_REQ-1 transactions.

## Test plan
- Bank reg 5 = 0xDEADBEEF; requester 2 reads addr 5 at edge k → `gnt` = 4'b0100 and `rb_addr` = 5 in k+1; `ack` = 4'b0100 and `rdata` = 0xDEADBEEF in k+2; `busy` falls in k+3.
- Requester 1 writes 0x12345678 to addr 31 → `rb_we` high for exactly one cycle with `rb_addr` = 31, `rb_wdata` = 0x12345678. A following read of 31 by requester 0 returns 0x12345678.
- All four `req` held high from reset release → grant order 0,1,2,3,0,1, one `ack` every 2 cycles, with no IDLE cycles in between.
- After requester 3 is granted, requesters 0 and 3 both request → requester 0 wins, then 3.
- `rst_n` pulsed low during the ACCESS of a write → `rb_we`, `gnt`, `busy` go to 0 immediately and no `ack` is issued. After release, pending requests 1 and 2 are served with 1 first (pointer was reset).
- `req[0]` raised only during an ACCESS cycle for another port and dropped before DONE → requester 0 is never granted; `rdata` is unchanged.
